// File: rtl/pc_fetch_unit.sv
// PC register plus single-outstanding instruction fetch over a valid/ready
// memory port. PC updates requested mid-fetch are deferred so pc_out tracks the fetch.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 0,
  parameter int          TIMEOUT_WIDTH  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_input,
  input  logic        pc_en,
  input  logic        fetch_start,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        fetch_busy,
  output logic        fetch_error
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] TO_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  state_t                   r_state;
  logic [31:0]              r_pc;
  logic [31:0]              r_addr;
  logic [31:0]              r_instr;
  logic [31:0]              r_pend_pc;
  logic                     r_pend_vld;
  logic [TIMEOUT_WIDTH-1:0] r_cnt;
  logic                     r_req_valid;
  logic                     r_instr_valid;
  logic                     r_err;
  logic                     r_busy;

  logic [31:0]              w_pend_pc;
  logic                     w_pend_vld;
  logic [TIMEOUT_WIDTH-1:0] w_cnt_nxt;
  logic                     w_timeout;

  // A pc_en on the returning-to-IDLE edge still wins over an older pending value.
  assign w_pend_pc  = pc_en ? pc_input : r_pend_pc;
  assign w_pend_vld = pc_en | r_pend_vld;
  assign w_cnt_nxt  = r_cnt + 1'b1;
  assign w_timeout  = TO_EN && (w_cnt_nxt == TO_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_addr        <= RESET_PC;
      r_instr       <= '0;
      r_pend_pc     <= '0;
      r_pend_vld    <= 1'b0;
      r_cnt         <= '0;
      r_req_valid   <= 1'b0;
      r_instr_valid <= 1'b0;
      r_err         <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_instr_valid <= 1'b0;
      r_err         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (fetch_start && (r_pc[1:0] == 2'b00)) begin
            r_addr      <= r_pc;
            r_req_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_REQ;
            if (pc_en) begin
              r_pend_pc  <= pc_input;
              r_pend_vld <= 1'b1;
            end
          end else begin
            // No fetch is in flight on a misaligned start, so a load applies directly.
            if (fetch_start) r_err <= 1'b1;
            if (pc_en)       r_pc  <= pc_input;
          end
        end
        S_REQ: begin
          if (pc_en) begin
            r_pend_pc  <= pc_input;
            r_pend_vld <= 1'b1;
          end
          if (imem_req_ready) begin
            r_req_valid <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (pc_en) begin
            r_pend_pc  <= pc_input;
            r_pend_vld <= 1'b1;
          end
          if (imem_resp_valid) begin
            r_instr       <= imem_resp_data;
            r_instr_valid <= 1'b1;
            r_state       <= S_DONE;
          end else if (w_timeout) begin
            r_err      <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
            r_pend_vld <= 1'b0;
            if (w_pend_vld) r_pc <= w_pend_pc;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_DONE: begin
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
          r_pend_vld <= 1'b0;
          if (w_pend_vld) r_pc <= w_pend_pc;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_addr;
  assign pc_out         = r_pc;
  assign instr_out      = r_instr;
  assign instr_valid    = r_instr_valid;
  assign fetch_busy     = r_busy;
  assign fetch_error    = r_err;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized fetch traffic against a transaction-level PC/instruction model;
// a negedge monitor drains a scoreboard of expected requests and results.
module tb_pc_fetch_unit;
  localparam int TO = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_input = '0;
  logic        pc_en = 1'b0;
  logic        fetch_start = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        fetch_busy;
  logic        fetch_error;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .pc_input(pc_input), .pc_en(pc_en),
    .fetch_start(fetch_start), .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .pc_out(pc_out), .instr_out(instr_out), .instr_valid(instr_valid),
    .fetch_busy(fetch_busy), .fetch_error(fetch_error));

  typedef struct {
    bit          is_err;
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Architectural model state
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_instr = 32'h0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req_valid) begin
        if (addr_q.size() == 0) chk("unexpected_req", {31'b0, imem_req_valid}, 32'd0);
        else begin
          chk("req_addr", imem_req_addr, addr_q[0]);
          if (imem_req_ready) void'(addr_q.pop_front());
        end
      end
      if (instr_valid || fetch_error) begin
        if (exp_q.size() == 0)
          chk("unexpected_out", {30'b0, instr_valid, fetch_error}, 32'd0);
        else begin
          me = exp_q.pop_front();
          chk("out_kind", {30'b0, instr_valid, fetch_error},
              me.is_err ? 32'd1 : 32'd2);
          chk("mon_instr_out", instr_out, me.instr);
          chk("mon_pc_out", pc_out, me.pc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    pc_en = 1'b0;
    fetch_start = 1'b0;
  endtask

  task automatic idle_load(logic [31:0] v);
    pc_en = 1'b1;
    pc_input = v;
    tick();
    pc_en = 1'b0;
    m_pc = v;
    chk("idle_pc_load", pc_out, v);
  endtask

  // One fetch at the model PC. en0: pc_en with fetch_start; en1: pc_en in first WAIT cycle.
  task automatic fetch(int rdly, int wdly, bit tmo, bit en0, logic [31:0] v0,
                       bit en1, logic [31:0] v1, bit noise, logic [31:0] d);
    exp_t        e;
    logic [31:0] fpc;
    logic [31:0] fin;
    fpc = m_pc;
    if (fpc[1:0] != 2'b00) begin
      e.is_err = 1'b1; e.instr = m_instr; e.pc = m_pc;
      exp_q.push_back(e);
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      chk("misalign_err", {31'b0, fetch_error}, 32'd1);
      chk("misalign_noreq", {31'b0, imem_req_valid}, 32'd0);
      chk("misalign_busy", {31'b0, fetch_busy}, 32'd0);
      tick();
      chk("misalign_err_pulse", {31'b0, fetch_error}, 32'd0);
      return;
    end
    fin = fpc;
    if (en0) fin = v0;
    if (en1) fin = v1;
    addr_q.push_back(fpc);
    if (tmo) begin e.is_err = 1'b1; e.instr = m_instr; e.pc = fin; end
    else     begin e.is_err = 1'b0; e.instr = d;       e.pc = fpc; end
    exp_q.push_back(e);

    fetch_start = 1'b1; pc_en = en0; pc_input = v0;
    tick();
    clr();
    chk("req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("busy_req", {31'b0, fetch_busy}, 32'd1);
    for (int i = 0; i < rdly; i++) begin
      if (noise) begin imem_resp_valid = 1'b1; imem_resp_data = $urandom; end
      tick();
      chk("req_hold", {31'b0, imem_req_valid}, 32'd1);
      chk("no_early_valid", {31'b0, instr_valid}, 32'd0);
    end
    imem_req_ready = 1'b1; imem_resp_valid = noise;
    tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    chk("req_dropped", {31'b0, imem_req_valid}, 32'd0);
    // In WAIT: optional deferred PC write plus an ignored fetch_start probe
    pc_en = en1; pc_input = v1; fetch_start = 1'b1;
    if (tmo) begin
      for (int i = 0; i < TO; i++) begin
        tick();
        clr();
        if (i < TO - 1) chk("tmo_not_yet", {31'b0, fetch_error}, 32'd0);
      end
      chk("tmo_err", {31'b0, fetch_error}, 32'd1);
      chk("tmo_busy", {31'b0, fetch_busy}, 32'd0);
      chk("tmo_instr_kept", instr_out, m_instr);
      chk("tmo_pc", pc_out, fin);
    end else begin
      for (int i = 0; i < wdly; i++) begin
        tick();
        clr();
      end
      imem_resp_valid = 1'b1; imem_resp_data = d;
      tick();
      clr();
      imem_resp_valid = 1'b0;
      chk("done_valid", {31'b0, instr_valid}, 32'd1);
      chk("done_instr", instr_out, d);
      chk("done_pc_held", pc_out, fpc);
      tick();
      chk("idle_valid_low", {31'b0, instr_valid}, 32'd0);
      chk("idle_busy", {31'b0, fetch_busy}, 32'd0);
      chk("idle_pc", pc_out, fin);
      chk("idle_instr_held", instr_out, d);
      m_instr = d;
    end
    m_pc = fin;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] v0;
    logic [31:0] v1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_addr", imem_req_addr, 32'h0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_flags", {28'b0, imem_req_valid, instr_valid, fetch_error, fetch_busy}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    fetch(0, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
    fetch(4, 1, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
    idle_load(32'h4);
    fetch(0, 0, 0, 1, 32'h10, 0, 0, 0, 32'hCAFE_0001);
    idle_load(32'h6);
    fetch(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    idle_load(32'h100);
    fetch(1, 0, 1, 0, 0, 0, 0, 0, 32'h0);
    fetch(0, 2, 0, 0, 0, 0, 0, 0, 32'hA5A5_5A5A);
    fetch(2, 1, 0, 1, 32'h200, 1, 32'h300, 0, 32'h0BAD_F00D);
    fetch(0, 0, 1, 0, 0, 1, 32'h404, 1, 32'h0);

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        v = $urandom;
        if ($urandom_range(0, 7) == 0) v[1:0] = 2'($urandom_range(1, 3));
        else v[1:0] = 2'b00;
        idle_load(v);
      end
      v0 = $urandom; v0[1:0] = 2'b00;
      v1 = $urandom; v1[1:0] = 2'b00;
      fetch($urandom_range(0, 4), $urandom_range(0, TO - 1),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), v0,
            ($urandom_range(0, 3) == 0), v1, ($urandom_range(0, 1) == 1), $urandom);
    end

    // Reset mid-WAIT, then a stale response must be ignored
    idle_load(32'h40);
    addr_q.push_back(32'h40);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    addr_q.delete();
    m_pc = 32'h0;
    m_instr = 32'h0;
    chk("arst_pc", pc_out, m_pc);
    chk("arst_addr", imem_req_addr, 32'h0);
    chk("arst_flags", {28'b0, imem_req_valid, instr_valid, fetch_error, fetch_busy}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = 32'hFFFF_0000;
    tick();
    imem_resp_valid = 1'b0;
    tick();
    chk("late_resp_instr", instr_out, m_instr);
    chk("late_resp_pc", pc_out, m_pc);
    chk("late_resp_flags", {28'b0, imem_req_valid, instr_valid, fetch_error, fetch_busy}, 32'h0);
    fetch(0, 0, 0, 0, 0, 0, 0, 0, 32'h7777_8888);

    tick();
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("addr_q_drained", addr_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the architectural PC register and performs instruction fetch from instruction memory.
- Consumes the next-PC value and PC-enable produced by the PC-control logic (`pc_input`/`pc_en`).
- Issues one valid/ready read request per fetch and returns the fetched word to the decode stage as a one-cycle pulse.
- Holds the PC stable while a fetch is outstanding, so `pc_out` always names the address of the instruction in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 0, maximum cycles spent in WAIT before a fetch error is raised; 0 disables the timeout.
- TIMEOUT_WIDTH, 8, width of the WAIT-cycle counter; must satisfy TIMEOUT_CYCLES < 2^TIMEOUT_WIDTH.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pc_input  input  32  next-PC value from PC control.
- pc_en  input  1  load request for `pc_input`.
- fetch_start  input  1  one-cycle pulse from the stage sequencer to fetch at the current PC.
- imem_req_valid  output  1  read request valid.
- imem_req_addr  output  32  read address.
- imem_req_ready  input  1  memory accepts the request.
- imem_resp_valid  input  1  read data valid.
- imem_resp_data  input  32  read data.
- pc_out  output  32  current PC.
- instr_out  output  32  last fetched instruction, held until the next fetch completes.
- instr_valid  output  1  one-cycle pulse when `instr_out` updates.
- fetch_busy  output  1  high in REQ, WAIT and DONE.
- fetch_error  output  1  one-cycle pulse on misalignment or timeout.

Behaviour:
- Reset (asynchronous, `rst_n`=0), applied from any state including mid-fetch:
  - state=IDLE, pc_out=RESET_PC, pending cleared.
  - instr_out=0; imem_req_valid, instr_valid, fetch_error, fetch_busy all 0.
  - imem_req_addr=RESET_PC.
  - A response arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - `fetch_start` with pc_out[1:0]==0: latch pc_out into imem_req_addr, go to REQ.
  - `fetch_start` with pc_out[1:0]!=0: stay in IDLE, pulse `fetch_error` next cycle, issue no request.
- REQ:
  - imem_req_valid=1; imem_req_addr is held stable until accepted.
  - On `imem_req_ready`=1 go to WAIT and clear the WAIT counter.
- WAIT:
  - On `imem_resp_valid`=1, capture imem_resp_data into instr_out and go to DONE.
  - The WAIT counter increments each cycle without a response. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES, pulse `fetch_error`, leave instr_out unchanged, apply any pending PC, and go to IDLE.
- DONE (exactly one cycle): instr_valid=1, apply any pending PC load, go to IDLE.
- Response handling: `imem_resp_valid` in IDLE or REQ is ignored. A response is never accepted in the same cycle the request is accepted.
- `fetch_start` while fetch_busy=1 is ignored (no queuing).
- PC update rules:
  - `pc_en` in IDLE without `fetch_start` loads pc_input at the same edge.
  - `pc_en` while busy, or coincident with `fetch_start`, writes a one-entry pending register (last write wins). That value reaches pc_out on the DONE→IDLE or timeout→IDLE edge.
  - The fetch always uses the pre-update PC.
- Minimum latency: fetch_start at cycle 0, ready at cycle 1, response at cycle 2 → instr_valid at cycle 3.
- No arithmetic on the PC inside this block; all 32 bits of pc_input are taken verbatim, and wrap-around is the caller's concern.

Test Plan:
- Reset, then fetch_start at PC=0 with memory ready/responding immediately, data 32'hDEAD_BEEF → req_valid in cycle 1 with addr 0; instr_valid in cycle 3 with instr_out=32'hDEAD_BEEF; pc_out stays 0.
- Hold imem_req_ready low for 4 cycles → req_valid and req_addr stay stable for all 5 cycles; no instr_valid until the response arrives.
- pc_en with pc_input=32'h10 in the same cycle as fetch_start (PC=4) → request addr=4; pc_out stays 4 until the DONE→IDLE edge, then becomes 32'h10.
- PC=32'h6 then fetch_start → no imem_req_valid, one-cycle fetch_error pulse, state remains IDLE.
- TIMEOUT_CYCLES=3, request accepted, no response → fetch_error pulse after 3 WAIT cycles; instr_out unchanged; the next fetch_start is honoured.
- Deassert rst_n during WAIT, then deliver a late imem_resp_valid → outputs hold reset values and the response is ignored; pc_out=RESET_PC.
